// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer:
// FSM states, opcode map, immediate-extension selects and decoded path flags.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_BEQ  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_MOVI = 4'h5;
  localparam logic [3:0] OP_BEQZ = 4'h6;
  localparam logic [3:0] OP_J    = 4'h7;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [3:0] EXT_SEL_STD  = 4'd0;
  localparam logic [3:0] EXT_SEL_BEQ  = 4'd1;
  localparam logic [3:0] EXT_SEL_ADDI = 4'd2;
  localparam logic [3:0] EXT_SEL_MOVI = 4'd3;
  localparam logic [3:0] EXT_SEL_BEQZ = 4'd4;
  localparam logic [3:0] EXT_SEL_JMP  = 4'd5;

  // Per-opcode routing through EXEC/MEM/WB.
  typedef struct packed {
    logic legal;
    logic is_mem;
    logic is_store;
    logic is_wb;
    logic is_branch;
    logic is_jump;
    logic uses_imm;
  } path_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Bundle of fetch, data-memory and datapath-control signals driven by the sequencer.
interface ctrl_sequencer_if;
  import ctrl_pkg::*;

  // Handshake: a req rises when the sequencer wants an access and stays high and
  // stable (dmem_we included) until the cycle its ack is 1; the transfer completes in
  // that cycle, ack may arrive in the very first req cycle, and acks seen while req=0 are ignored.
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_ack;
  logic        alu_zero;

  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        pc_inc;
  logic        pc_we;
  logic        rf_we;
  logic [3:0]  ext_sel;
  logic        ext_sign_ena;
  logic [23:0] imm_field;
  logic        alu_src_imm;
  logic        fault;
  state_e      dbg_state;

  modport master (
    input  imem_rdata, imem_ack, dmem_ack, alu_zero,
    output imem_req, dmem_req, dmem_we, ir_we, pc_inc, pc_we, rf_we,
           ext_sel, ext_sign_ena, imm_field, alu_src_imm, fault, dbg_state
  );

  modport slave (
    output imem_rdata, imem_ack, dmem_ack, alu_zero,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_inc, pc_we, rf_we,
           ext_sel, ext_sign_ena, imm_field, alu_src_imm, fault, dbg_state
  );

endinterface

// File: rtl/ctrl_opdecode.sv
// Combinational opcode decoder: op/U bits to immediate-extension controls and
// the path the instruction takes after EXEC.
module ctrl_opdecode
  import ctrl_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic       u_i,
  output logic [3:0] ext_sel_o,
  output logic       sign_ena_o,
  output path_t      path_o
);

  always_comb begin
    ext_sel_o    = EXT_SEL_STD;
    sign_ena_o   = 1'b1;
    path_o       = '0;
    path_o.legal = 1'b1;
    case (op_i)
      OP_ALU: begin
        path_o.is_wb = 1'b1;
      end
      OP_LD: begin
        path_o.is_mem   = 1'b1;
        path_o.is_wb    = 1'b1;
        path_o.uses_imm = 1'b1;
      end
      OP_ST: begin
        path_o.is_mem   = 1'b1;
        path_o.is_store = 1'b1;
        path_o.uses_imm = 1'b1;
      end
      OP_BEQ: begin
        ext_sel_o        = EXT_SEL_BEQ;
        path_o.is_branch = 1'b1;
      end
      OP_ADDI: begin
        ext_sel_o       = EXT_SEL_ADDI;
        sign_ena_o      = ~u_i;
        path_o.is_wb    = 1'b1;
        path_o.uses_imm = 1'b1;
      end
      OP_MOVI: begin
        ext_sel_o       = EXT_SEL_MOVI;
        sign_ena_o      = ~u_i;
        path_o.is_wb    = 1'b1;
        path_o.uses_imm = 1'b1;
      end
      OP_BEQZ: begin
        ext_sel_o        = EXT_SEL_BEQZ;
        path_o.is_branch = 1'b1;
      end
      OP_J: begin
        ext_sel_o      = EXT_SEL_JMP;
        path_o.is_jump = 1'b1;
      end
      OP_NOP: begin
        path_o.legal = 1'b1;
      end
      default: begin
        path_o.legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM with instruction register,
// held immediate-extension controls and a memory-ack timeout trap.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
)
(
  input  logic              clk,
  input  logic              rst,
  ctrl_sequencer_if.master  bus
);

  localparam int unsigned   CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);
  localparam bit            TMO_EN   = (MEM_TIMEOUT != 0);

  state_e        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [3:0]    ext_sel_q, ext_sel_d;
  logic          ext_sign_q, ext_sign_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] wait_q, wait_d;

  logic [3:0]    dec_ext_sel;
  logic          dec_sign_ena;
  path_t         path;

  logic imem_req_c, dmem_req_c, ir_we_c, pc_inc_c, pc_we_c, rf_we_c;
  logic tmo_hit, data_phase;
  logic unused_ir;

  ctrl_opdecode u_opdecode (
    .op_i       (ir_q[31:28]),
    .u_i        (ir_q[24]),
    .ext_sel_o  (dec_ext_sel),
    .sign_ena_o (dec_sign_ena),
    .path_o     (path)
  );

  // The count value that, with no ack this cycle, completes the timeout window.
  assign tmo_hit    = TMO_EN && (wait_q == TMO_LAST);
  assign data_phase = (state_q == EXEC) || (state_q == MEM) || (state_q == WB);
  assign unused_ir  = ^ir_q[27:25];

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ext_sel_d  = ext_sel_q;
    ext_sign_d = ext_sign_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    pc_inc_c   = 1'b0;
    pc_we_c    = 1'b0;
    rf_we_c    = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ack) begin
          ir_we_c  = 1'b1;
          pc_inc_c = 1'b1;
          ir_d     = bus.imem_rdata;
          state_d  = DECODE;
        end else if (tmo_hit) begin
          state_d = TRAP;
        end
      end
      DECODE: begin
        if (path.legal) begin
          ext_sel_d  = dec_ext_sel;
          ext_sign_d = dec_sign_ena;
          state_d    = EXEC;
        end else begin
          state_d = TRAP;
        end
      end
      EXEC: begin
        pc_we_c = path.is_jump | (path.is_branch & bus.alu_zero);
        if (path.is_mem)     state_d = MEM;
        else if (path.is_wb) state_d = WB;
        else                 state_d = FETCH;
      end
      MEM: begin
        dmem_req_c = 1'b1;
        if (bus.dmem_ack)  state_d = path.is_wb ? WB : FETCH;
        else if (tmo_hit)  state_d = TRAP;
      end
      WB: begin
        rf_we_c = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase
  end

  // Wait counter restarts on every state change and only runs while stalled on an ack.
  always_comb begin
    wait_d  = wait_q;
    fault_d = fault_q | (state_d == TRAP);
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((imem_req_c && !bus.imem_ack) || (dmem_req_c && !bus.dmem_ack)) begin
      wait_d = wait_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      ir_q       <= '0;
      ext_sel_q  <= EXT_SEL_STD;
      ext_sign_q <= 1'b1;
      fault_q    <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ext_sel_q  <= ext_sel_d;
      ext_sign_q <= ext_sign_d;
      fault_q    <= fault_d;
      wait_q     <= wait_d;
    end
  end

  // Reset masks requests and strobes immediately so an in-flight access is abandoned.
  assign bus.imem_req     = imem_req_c & ~rst;
  assign bus.dmem_req     = dmem_req_c & ~rst;
  assign bus.dmem_we      = dmem_req_c & path.is_store & ~rst;
  assign bus.ir_we        = ir_we_c & ~rst;
  assign bus.pc_inc       = pc_inc_c & ~rst;
  assign bus.pc_we        = pc_we_c & ~rst;
  assign bus.rf_we        = rf_we_c & ~rst;
  assign bus.alu_src_imm  = path.uses_imm & data_phase & ~rst;
  assign bus.ext_sel      = ext_sel_q;
  assign bus.ext_sign_ena = ext_sign_q;
  assign bus.imm_field    = ir_q[23:0];
  assign bus.fault        = fault_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: table of instructions scored through an expected queue,
// plus hand sequences for trap, timeout and reset-during-access.
module tb_ctrl_sequencer;
  import ctrl_pkg::*;

  localparam int unsigned TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ctrl_sequencer_if bus();

  ctrl_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]  cycles;
    logic [7:0]  rf_at;
    logic [7:0]  rf_cnt;
    logic [7:0]  pc_at;
    logic [7:0]  dreq;
    logic        dwe;
    logic        ext_care;
    logic [3:0]  ext_sel;
    logic        sign;
    logic        src_imm;
    logic [23:0] imm;
    logic        excl_ok;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);
  logic [OBS_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        az;
    int          delay;
    int          cyc;
    int          rf_at;
    int          pc_at;
    int          dreq;
    logic        dwe;
    logic        ext_care;
    logic [3:0]  ext;
    logic        sign;
    logic        src;
  } vec_t;

  // ---------------- driver ----------------
  // Starts in FETCH; returns on the first cycle of the following FETCH.
  task automatic exec_instr(input logic [31:0] instr, input logic az, input int delay,
                            output obs_t o);
    bit fetched = 1'b0;
    bit done    = 1'b0;
    int dreq    = 0;
    int nstrobe;
    o = '0;
    o.excl_ok = 1'b1;
    bus.alu_zero = az;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      #1;
      if (bus.imem_req) begin
        if (!fetched) begin
          bus.imem_rdata = instr;
          bus.imem_ack   = 1'b1;
          fetched        = 1'b1;
        end else begin
          done     = 1'b1;
          o.cycles = 8'(c - 1);
        end
      end
      if (bus.dmem_req) begin
        dreq++;
        o.dwe = o.dwe | bus.dmem_we;
        if (dreq > delay) bus.dmem_ack = 1'b1;
      end
      #1;
      if (bus.rf_we) begin
        o.rf_at  = 8'(c);
        o.rf_cnt = o.rf_cnt + 8'd1;
      end
      if (bus.pc_we) o.pc_at = 8'(c);
      if (c == 3) begin
        o.ext_sel = bus.ext_sel;
        o.sign    = bus.ext_sign_ena;
        o.src_imm = bus.alu_src_imm;
        o.imm     = bus.imm_field;
      end
      nstrobe = int'(bus.ir_we) + int'(bus.pc_we) + int'(bus.rf_we);
      if (nstrobe > 1 || bus.pc_inc != bus.ir_we) o.excl_ok = 1'b0;
    end
    o.dreq = 8'(dreq);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic run_timeout(input int ack_cycle, output int fault_at, output logic req_at_end);
    do_reset();
    fault_at = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) @(negedge clk);
      bus.imem_rdata = 32'hF000_0000;
      bus.imem_ack   = (c == ack_cycle);
      #1;
      if (bus.fault && fault_at == 0) fault_at = c;
    end
    req_at_end   = bus.imem_req;
    bus.imem_ack = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t vecs[15];

  initial begin
    obs_t o, e;
    int   bad, fault_at;
    logic req_end;

    vecs[0]  = '{32'h4000_7FFF, 1'b0, 0, 4, 4, 0, 0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1};
    vecs[1]  = '{32'h4100_1234, 1'b0, 0, 4, 4, 0, 0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1};
    vecs[2]  = '{32'h50AB_CDEF, 1'b0, 0, 4, 4, 0, 0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1};
    vecs[3]  = '{32'h5100_0005, 1'b1, 0, 4, 4, 0, 0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1};
    vecs[4]  = '{32'h0E12_3456, 1'b1, 0, 4, 4, 0, 0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[5]  = '{32'h1000_0010, 1'b0, 0, 5, 5, 0, 1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1};
    vecs[6]  = '{32'h11FF_FFF0, 1'b0, 3, 8, 8, 0, 4, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1};
    vecs[7]  = '{32'h2000_0008, 1'b0, 0, 4, 0, 0, 1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1};
    vecs[8]  = '{32'h2000_00FC, 1'b1, 2, 6, 0, 0, 3, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1};
    vecs[9]  = '{32'h3000_0004, 1'b1, 0, 3, 0, 3, 0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[10] = '{32'h30FF_FFFC, 1'b0, 0, 3, 0, 0, 0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0};
    vecs[11] = '{32'h6000_0010, 1'b1, 0, 3, 0, 3, 0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0};
    vecs[12] = '{32'h6100_0020, 1'b0, 0, 3, 0, 0, 0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0};
    vecs[13] = '{32'h7000_1000, 1'b0, 0, 3, 0, 3, 0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0};
    vecs[14] = '{32'hF000_0000, 1'b1, 0, 3, 0, 0, 0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};

    bus.imem_rdata = '0;
    bus.imem_ack   = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.alu_zero   = 1'b0;

    // Reset state, observed while rst is still high.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(bus.dbg_state), 32'(FETCH));
    chk("rst_reqs", 32'({bus.imem_req, bus.dmem_req}), 32'd0);
    chk("rst_strobes", 32'({bus.ir_we, bus.pc_inc, bus.pc_we, bus.rf_we}), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_ext", 32'({bus.ext_sel, bus.ext_sign_ena}), 32'h01);
    chk("rst_imm", 32'(bus.imm_field), 32'd0);
    rst = 1'b0;

    // Table-driven instruction stream.
    for (int i = 0; i < 15; i++) begin
      e          = '0;
      e.cycles   = 8'(vecs[i].cyc);
      e.rf_at    = 8'(vecs[i].rf_at);
      e.rf_cnt   = (vecs[i].rf_at != 0) ? 8'd1 : 8'd0;
      e.pc_at    = 8'(vecs[i].pc_at);
      e.dreq     = 8'(vecs[i].dreq);
      e.dwe      = vecs[i].dwe;
      e.ext_care = vecs[i].ext_care;
      e.ext_sel  = vecs[i].ext;
      e.sign     = vecs[i].sign;
      e.src_imm  = vecs[i].src;
      e.imm      = vecs[i].instr[23:0];
      e.excl_ok  = 1'b1;
      exp_q.push_back(e);
      exec_instr(vecs[i].instr, vecs[i].az, vecs[i].delay, o);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_cycles", i), 32'(o.cycles), 32'(e.cycles));
      chk($sformatf("v%0d_rf_at", i), 32'(o.rf_at), 32'(e.rf_at));
      chk($sformatf("v%0d_rf_cnt", i), 32'(o.rf_cnt), 32'(e.rf_cnt));
      chk($sformatf("v%0d_pc_at", i), 32'(o.pc_at), 32'(e.pc_at));
      chk($sformatf("v%0d_dreq", i), 32'(o.dreq), 32'(e.dreq));
      chk($sformatf("v%0d_dwe", i), 32'(o.dwe), 32'(e.dwe));
      chk($sformatf("v%0d_src_imm", i), 32'(o.src_imm), 32'(e.src_imm));
      chk($sformatf("v%0d_imm", i), 32'(o.imm), 32'(e.imm));
      chk($sformatf("v%0d_excl", i), 32'(o.excl_ok), 32'(e.excl_ok));
      if (e.ext_care) begin
        chk($sformatf("v%0d_ext_sel", i), 32'(o.ext_sel), 32'(e.ext_sel));
        chk($sformatf("v%0d_sign", i), 32'(o.sign), 32'(e.sign));
      end
    end
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    // Illegal opcode traps and stays trapped until reset.
    @(negedge clk);
    bus.imem_rdata = 32'h9ABC_DEF0;
    bus.imem_ack   = 1'b1;
    #1;
    chk("ill_ir_we", 32'(bus.ir_we), 32'd1);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    #1;
    chk("ill_decode_no_fault", 32'(bus.fault), 32'd0);
    @(negedge clk);
    #1;
    chk("ill_fault", 32'(bus.fault), 32'd1);
    chk("ill_state", 32'(bus.dbg_state), 32'(TRAP));
    chk("ill_imm", 32'(bus.imm_field), 32'hBC_DEF0);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.imem_ack = 1'($urandom_range(0, 1));
      bus.dmem_ack = 1'($urandom_range(0, 1));
      bus.alu_zero = 1'($urandom_range(0, 1));
      #1;
      if ({bus.imem_req, bus.dmem_req, bus.ir_we, bus.pc_inc, bus.pc_we, bus.rf_we} != 6'd0 ||
          !bus.fault || bus.dbg_state != TRAP)
        bad++;
    end
    chk("trap_hold_bad_cycles", 32'(bad), 32'd0);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("trap_rst_fault", 32'(bus.fault), 32'd0);
    chk("trap_rst_state", 32'(bus.dbg_state), 32'(FETCH));
    chk("trap_rst_imm", 32'(bus.imm_field), 32'd0);
    chk("trap_rst_req", 32'(bus.imem_req), 32'd0);
    rst = 1'b0;
    #1;
    chk("trap_exit_req", 32'(bus.imem_req), 32'd1);

    // Fetch timeout: no ack traps after exactly TMO cycles; ack on the last cycle wins.
    run_timeout(0, fault_at, req_end);
    chk("tmo_fault_cycle", 32'(fault_at), 32'(TMO + 1));
    chk("tmo_req_dropped", 32'(req_end), 32'd0);
    run_timeout(TMO, fault_at, req_end);
    chk("tmo_ack_last_no_fault", 32'(fault_at), 32'd0);

    // Reset in the middle of a store's MEM phase, then a stray dmem_ack.
    do_reset();
    @(negedge clk);
    bus.imem_rdata = 32'h2000_0040;
    bus.imem_ack   = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("st_mem_req", 32'({bus.dmem_req, bus.dmem_we}), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("st_rst_req_dropped", 32'(bus.dmem_req), 32'd0);
    chk("st_rst_state", 32'(bus.dbg_state), 32'(FETCH));
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      bus.dmem_ack = 1'b1;
      #1;
      if (bus.dmem_req || bus.rf_we || bus.fault || bus.dbg_state != FETCH) bad++;
    end
    bus.dmem_ack = 1'b0;
    chk("stray_ack_bad_cycles", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
